// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM slot framer.
package tdm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
    S_GUARD
  } state_t;

  localparam logic [7:0] PREAMBLE_DEF  = 8'hA5;
  localparam logic [7:0] IDLE_WORD_DEF = 8'h00;

  // Header word layout: channel id in the upper nibble, burst length in the lower.
  localparam int CH_LSB      = 4;
  localparam int LEN_LSB     = 0;
  localparam int HDR_FIELD_W = 4;

  // Value the free-running frame counter must present after prev.
  function automatic logic [31:0] next_count(input logic [31:0] prev,
                                             input logic [31:0] final_count);
    return (prev == final_count) ? 32'd0 : prev + 32'd1;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_decode.sv
// Splits a frame count into slot index, offset within the slot, and guard flag.
module tdm_slot_decode #(
  parameter int NUM_CH   = 4,
  parameter int SLOT_LEN = 64,
  parameter int COUNT_W  = 9,
  parameter int SLOT_W   = 2,
  parameter int OFF_W    = 6
) (
  input  logic [COUNT_W-1:0] count,
  output logic [SLOT_W-1:0]  slot,
  output logic [OFF_W-1:0]   off,
  output logic               in_guard
);

  // Constant divisor/modulus; slot is only meaningful while in_guard is low.
  always_comb begin
    slot     = SLOT_W'(32'(count) / 32'(SLOT_LEN));
    off      = OFF_W'(32'(count) % 32'(SLOT_LEN));
    in_guard = (32'(count) >= 32'(NUM_CH * SLOT_LEN));
  end

endmodule

// File: rtl/tdm_slot_framer.sv
// TDM slot framer: one preamble/header/payload burst per channel slot per frame,
// driven by the upstream free-running frame counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no burst in this slot (unsynced, channel unavailable, abort)
// S_PREAMBLE | emitting the preamble word (slot offset 0)
// S_HEADER   | emitting the header word (slot offset 1)
// S_PAYLOAD  | popping and emitting payload beats from the slot owner
// S_GUARD    | burst finished, filler until the next slot boundary
//
// The state register holds the phase of the word emitted for the previously
// sampled count; state_next is the phase for the count currently on the input,
// and all word outputs are registered from state_next.
module tdm_slot_framer
  import tdm_pkg::*;
#(
  parameter int         FINAL_COUNT = 256,
  parameter int         NUM_CH      = 4,
  parameter int         SLOT_LEN    = 64,
  parameter int         BURST_LEN   = 32,
  parameter int         DATA_W      = 8,
  parameter logic [7:0] PREAMBLE    = PREAMBLE_DEF,
  parameter logic [7:0] IDLE_WORD   = IDLE_WORD_DEF,
  localparam int        COUNT_W     = $clog2(FINAL_COUNT) + 1,
  localparam int        CH_W        = clog2_min1(NUM_CH),
  localparam int        OFF_W       = clog2_min1(SLOT_LEN),
  localparam int        BEAT_W      = clog2_min1(BURST_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNT_W-1:0]       count,
  input  logic [NUM_CH-1:0]        ch_avail,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     m_valid,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_sof,
  output logic                     m_sob,
  output logic [CH_W-1:0]          m_ch,
  output logic [NUM_CH-1:0]        underrun,
  output logic                     sync_err
);

  if (NUM_CH * SLOT_LEN > FINAL_COUNT + 1) begin : g_err_slots
    $error("tdm_slot_framer: NUM_CH*SLOT_LEN exceeds the frame period");
  end
  if (BURST_LEN + 2 > SLOT_LEN) begin : g_err_burst
    $error("tdm_slot_framer: burst plus preamble and header does not fit a slot");
  end
  if (DATA_W < 8) begin : g_err_width
    $error("tdm_slot_framer: DATA_W must be at least 8");
  end

  localparam logic [DATA_W-1:0] PREAMBLE_W  = DATA_W'(PREAMBLE);
  localparam logic [DATA_W-1:0] IDLE_W      = DATA_W'(IDLE_WORD);
  localparam logic [BEAT_W-1:0] BEAT_RELOAD = BEAT_W'(BURST_LEN - 1);

  logic [CH_W-1:0]    slot;
  logic [OFF_W-1:0]   off;
  logic               in_guard;

  state_t             state, state_next;
  logic [BEAT_W-1:0]  beat_cnt, beat_next;
  logic               synced, synced_next;
  logic [COUNT_W-1:0] prev_count;
  logic               prev_valid;
  logic               mismatch;
  logic               count_zero;
  logic               at_boundary;
  logic               start_burst;
  logic               in_burst;
  logic [DATA_W-1:0]  slot_data;
  logic [DATA_W-1:0]  header_word;
  logic [DATA_W-1:0]  word_next;
  logic [NUM_CH-1:0]  slot_onehot;

  tdm_slot_decode #(
    .NUM_CH   (NUM_CH),
    .SLOT_LEN (SLOT_LEN),
    .COUNT_W  (COUNT_W),
    .SLOT_W   (CH_W),
    .OFF_W    (OFF_W)
  ) u_decode (
    .count    (count),
    .slot     (slot),
    .off      (off),
    .in_guard (in_guard)
  );

  // Count continuity check and frame sync tracking; a count of 0 syncs in the same cycle
  // so slot 0 of the first frame can burst.
  always_comb begin
    count_zero  = (count == '0);
    mismatch    = prev_valid &&
                  (count != COUNT_W'(next_count(32'(prev_count), 32'(FINAL_COUNT))));
    synced_next = !mismatch && (synced || count_zero);
    at_boundary = (off == '0);
    start_burst = at_boundary && !in_guard && synced_next && ch_avail[slot];
  end

  // Next-state: a discontinuity aborts, a slot boundary re-evaluates, otherwise walk the burst.
  always_comb begin
    state_next = state;
    beat_next  = beat_cnt;
    if (mismatch) begin
      state_next = S_IDLE;
    end else if (at_boundary) begin
      state_next = start_burst ? S_PREAMBLE : S_IDLE;
    end else begin
      case (state)
        S_PREAMBLE: state_next = S_HEADER;
        S_HEADER: begin
          state_next = S_PAYLOAD;
          beat_next  = BEAT_RELOAD;
        end
        S_PAYLOAD: begin
          if (beat_cnt == '0) state_next = S_GUARD;
          else                beat_next  = beat_cnt - 1'b1;
        end
        S_IDLE:  state_next = S_IDLE;
        S_GUARD: state_next = S_GUARD;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Word selection for the count being sampled; ch_ready pops in step with the capture.
  always_comb begin
    slot_data   = ch_data[slot*DATA_W +: DATA_W];
    header_word = '0;
    header_word[CH_LSB +: HDR_FIELD_W]  = HDR_FIELD_W'(slot);
    header_word[LEN_LSB +: HDR_FIELD_W] = HDR_FIELD_W'(BURST_LEN);
    slot_onehot = NUM_CH'(1) << slot;
    in_burst    = (state_next == S_PREAMBLE) || (state_next == S_HEADER) ||
                  (state_next == S_PAYLOAD);
    word_next   = IDLE_W;
    case (state_next)
      S_PREAMBLE: word_next = PREAMBLE_W;
      S_HEADER:   word_next = header_word;
      S_PAYLOAD:  word_next = ch_valid[slot] ? slot_data : IDLE_W;
      default:    word_next = IDLE_W;
    endcase
    ch_ready = (!rst && (state_next == S_PAYLOAD)) ? slot_onehot : '0;
  end

  // State, sync history, registered outputs and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      synced     <= 1'b0;
      prev_count <= '0;
      prev_valid <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= IDLE_W;
      m_sof      <= 1'b0;
      m_sob      <= 1'b0;
      m_ch       <= '0;
      underrun   <= '0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_next;
      beat_cnt   <= beat_next;
      synced     <= synced_next;
      prev_count <= count;
      prev_valid <= 1'b1;
      m_valid    <= in_burst;
      m_data     <= word_next;
      m_sof      <= count_zero;
      m_sob      <= (state_next == S_PREAMBLE);
      m_ch       <= in_burst ? slot : '0;
      underrun   <= underrun | (ch_ready & ~ch_valid);
      sync_err   <= sync_err | mismatch;
    end
  end

  // A burst can never still be mid-flight when the next slot boundary arrives.
  a_boundary_clear: assert property (@(posedge clk) disable iff (rst)
    !(at_boundary && !mismatch &&
      ((state == S_PREAMBLE) || (state == S_HEADER) ||
       ((state == S_PAYLOAD) && (beat_cnt != '0)))));

endmodule

// File: tb/tb_tdm_slot_framer.sv
// Scoreboard bench for tdm_slot_framer with default parameters.
module tb_tdm_slot_framer;
  import tdm_pkg::*;

  localparam int FINAL_COUNT = 256;
  localparam int NUM_CH      = 4;
  localparam int SLOT_LEN    = 64;
  localparam int BURST_LEN   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  count;
  logic [3:0]  ch_avail;
  logic [3:0]  ch_valid;
  logic [31:0] ch_data;
  logic [3:0]  ch_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_sof;
  logic        m_sob;
  logic [1:0]  m_ch;
  logic [3:0]  underrun;
  logic        sync_err;

  tdm_slot_framer dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .ch_avail (ch_avail),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_sof    (m_sof),
    .m_sob    (m_sob),
    .m_ch     (m_ch),
    .underrun (underrun),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       sof;
    logic       sob;
    logic [1:0] ch;
    logic [3:0] ur;
    logic       se;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cnt;
  int vcount;
  int r2count;
  int vc_ch[4];

  // Reference model state: offset-based view of the frame.
  bit         md_synced;
  bit         md_burst;
  bit         md_pv;
  int         md_prev;
  logic [3:0] md_ur;
  logic       md_se;

  // Underrun window: ch_valid[uv_ch] low for payload beats uv_lo..uv_hi.
  bit uv_en;
  int uv_ch;
  int uv_lo;
  int uv_hi;

  task automatic clear_tally();
    vcount  = 0;
    r2count = 0;
    for (int i = 0; i < 4; i++) vc_ch[i] = 0;
  endtask

  // One cycle: drive count/data, predict, check ch_ready, then check registered outputs.
  task automatic step();
    exp_t       e;
    logic [3:0] exp_ready;
    int         off;
    int         slot;
    int         beat;
    bit         guard;
    bit         mism;
    bit         in_b;
    off   = cnt % SLOT_LEN;
    slot  = cnt / SLOT_LEN;
    guard = (cnt >= NUM_CH * SLOT_LEN);
    beat  = off - 2;
    count = 9'(cnt);
    ch_valid = 4'hF;
    if (uv_en && !guard && slot == uv_ch && beat >= uv_lo && beat <= uv_hi)
      ch_valid[uv_ch] = 1'b0;
    for (int i = 0; i < 4; i++) ch_data[i*8 +: 8] = 8'(16 * i + beat);

    exp_ready = 4'h0;
    e.v = 1'b0; e.d = 8'h00; e.sof = 1'b0; e.sob = 1'b0; e.ch = 2'd0;
    if (rst) begin
      md_synced = 1'b0;
      md_burst  = 1'b0;
      md_pv     = 1'b0;
      md_ur     = 4'h0;
      md_se     = 1'b0;
    end else begin
      mism = md_pv && (cnt != int'(next_count(32'(md_prev), 32'(FINAL_COUNT))));
      if (mism) begin
        md_se     = 1'b1;
        md_synced = 1'b0;
        md_burst  = 1'b0;
      end else begin
        if (cnt == 0) md_synced = 1'b1;
        if (off == 0) md_burst = guard ? 1'b0 : (md_synced && ch_avail[slot]);
      end
      md_prev = cnt;
      md_pv   = 1'b1;
      in_b    = md_burst && !guard && (off <= BURST_LEN + 1);
      e.sof   = (cnt == 0);
      if (in_b) begin
        e.v   = 1'b1;
        e.sob = (off == 0);
        e.ch  = 2'(slot);
        if (off == 0)      e.d = 8'hA5;
        else if (off == 1) e.d = 8'(slot * 16) | 8'(BURST_LEN % 16);
        else begin
          e.d = ch_valid[slot] ? 8'(16 * slot + beat) : 8'h00;
          exp_ready[slot] = 1'b1;
          if (!ch_valid[slot]) md_ur[slot] = 1'b1;
        end
      end
    end
    e.ur = md_ur;
    e.se = md_se;

    #1;
    checks++;
    if (ch_ready !== exp_ready) begin
      errors++;
      $display("FAIL ch_ready count=%0d got %h exp %h", cnt, ch_ready, exp_ready);
    end
    if (ch_ready[2]) r2count++;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if ({m_valid, m_data, m_sof, m_sob, m_ch} !== {e.v, e.d, e.sof, e.sob, e.ch}) begin
      errors++;
      $display("FAIL word count=%0d got v=%b d=%h sof=%b sob=%b ch=%0d exp v=%b d=%h sof=%b sob=%b ch=%0d",
               cnt, m_valid, m_data, m_sof, m_sob, m_ch, e.v, e.d, e.sof, e.sob, e.ch);
    end
    checks++;
    if ({underrun, sync_err} !== {e.ur, e.se}) begin
      errors++;
      $display("FAIL flags count=%0d got underrun=%b sync_err=%b exp underrun=%b sync_err=%b",
               cnt, underrun, sync_err, e.ur, e.se);
    end
    if (m_valid) begin
      vcount++;
      vc_ch[m_ch]++;
    end
    cnt = int'(next_count(32'(cnt), 32'(FINAL_COUNT)));
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next value to drive is target; bounded.
  task automatic run_to(input int target);
    int n;
    n = 0;
    while (cnt != target && n < 600) begin
      step();
      n++;
    end
    if (cnt != target) begin
      errors++;
      $display("FAIL run_to target=%0d stopped at %0d", target, cnt);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    cnt      = 5;
    ch_avail = 4'hF;
    uv_en    = 1'b0;
    run_n(3);
    checks++;
    if ({m_valid, m_data, m_sof, m_sob, m_ch, underrun, sync_err} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h sof=%b sob=%b exp all zero",
               m_valid, m_data, m_sof, m_sob);
    end
    rst = 1'b0;
    clear_tally();
    run_to(0);
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL pre_sync_valid got %0d words exp 0", vcount);
    end
    step();
    checks++;
    if ({m_sof, m_sob, m_valid, m_data} !== {1'b1, 1'b1, 1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL first_sof_sob got sof=%b sob=%b v=%b d=%h exp 1 1 1 a5",
               m_sof, m_sob, m_valid, m_data);
    end
  endtask

  task automatic test_full_frame();
    run_to(0);
    clear_tally();
    run_n(FINAL_COUNT + 1);
    checks++;
    if (vcount !== 136) begin
      errors++;
      $display("FAIL full_frame_words got %0d exp 136", vcount);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vc_ch[i] !== 34) begin
        errors++;
        $display("FAIL full_frame_ch%0d got %0d exp 34", i, vc_ch[i]);
      end
    end
  endtask

  // Slot 2 unavailable at its boundary; availability returning mid-slot is ignored.
  task automatic test_unavail();
    run_to(0);
    ch_avail = 4'b1011;
    clear_tally();
    run_to(130);
    ch_avail = 4'hF;
    run_to(0);
    checks++;
    if (vc_ch[2] !== 0 || r2count !== 0) begin
      errors++;
      $display("FAIL unavail_slot2 got words=%0d pops=%0d exp 0 0", vc_ch[2], r2count);
    end
    checks++;
    if (vcount !== 102) begin
      errors++;
      $display("FAIL unavail_total got %0d exp 102", vcount);
    end
  endtask

  task automatic test_underrun();
    run_to(0);
    uv_en = 1'b1; uv_ch = 1; uv_lo = 5; uv_hi = 7;
    clear_tally();
    run_n(FINAL_COUNT + 1);
    uv_en = 1'b0;
    checks++;
    if (vc_ch[1] !== 34) begin
      errors++;
      $display("FAIL underrun_len got %0d exp 34", vc_ch[1]);
    end
    checks++;
    if (underrun !== 4'b0010) begin
      errors++;
      $display("FAIL underrun_flag got %b exp 0010", underrun);
    end
    run_n(FINAL_COUNT + 1);
    checks++;
    if (underrun !== 4'b0010) begin
      errors++;
      $display("FAIL underrun_sticky got %b exp 0010", underrun);
    end
  endtask

  // Jump from 20 (inside slot 0 payload) to 100.
  task automatic test_sync();
    run_to(0);
    run_to(21);
    cnt = 100;
    step();
    checks++;
    if (m_valid !== 1'b0 || sync_err !== 1'b1) begin
      errors++;
      $display("FAIL sync_abort got v=%b sync_err=%b exp 0 1", m_valid, sync_err);
    end
    clear_tally();
    run_to(0);
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL sync_quiet got %0d words exp 0", vcount);
    end
    clear_tally();
    run_n(FINAL_COUNT + 1);
    checks++;
    if (vcount !== 136 || sync_err !== 1'b1) begin
      errors++;
      $display("FAIL sync_resume got words=%0d sync_err=%b exp 136 1", vcount, sync_err);
    end
  endtask

  // Reset at slot 3 payload beat 10 (count 204).
  task automatic test_reset_mid();
    run_to(204);
    rst = 1'b1;
    step();
    checks++;
    if ({m_valid, m_data, m_sob, m_ch, underrun, sync_err} !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got v=%b d=%h ur=%b se=%b exp all zero",
               m_valid, m_data, underrun, sync_err);
    end
    step();
    rst = 1'b0;
    clear_tally();
    run_to(0);
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d words exp 0", vcount);
    end
    clear_tally();
    run_n(FINAL_COUNT + 1);
    checks++;
    if (vcount !== 136) begin
      errors++;
      $display("FAIL reset_mid_resume got %0d words exp 136", vcount);
    end
  endtask

  initial begin
    rst      = 1'b1;
    count    = '0;
    ch_avail = 4'hF;
    ch_valid = 4'hF;
    ch_data  = '0;
    uv_en    = 1'b0;
    uv_ch    = 0;
    uv_lo    = 0;
    uv_hi    = 0;
    clear_tally();
    test_reset();
    test_full_frame();
    test_unavail();
    test_underrun();
    test_sync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
